// File: rtl/img_rom_scan_ctrl_if.sv
// Pixel stream bundle between the image ROM scanner and the filter/display path.
// The master drives data, valid and frame/line markers; the slave returns ready.
interface img_rom_scan_ctrl_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_sof;
    logic                  m_eol;
    logic                  m_eof;

    modport master (output m_data, m_valid, m_sof, m_eol, m_eof, input m_ready);
    modport slave  (input m_data, m_valid, m_sof, m_eol, m_eof, output m_ready);
endinterface

// File: rtl/img_rom_scan_ctrl.sv
// Raster-order read scheduler for the single-port image ROM. It shares the ROM
// between a ready/valid pixel stream and an alternating-priority auxiliary read port.
module img_rom_scan_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 24,
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    output logic                  busy,
    img_rom_scan_ctrl_if.master   m_if,
    input  logic                  aux_req,
    input  logic [ADDR_WIDTH-1:0] aux_addr,
    output logic                  aux_gnt,
    output logic [DATA_WIDTH-1:0] aux_data,
    output logic                  aux_valid,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rd_data
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int FW = DATA_WIDTH + 3;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t                state_r, state_s;
    logic                  busy_r;
    logic [XW-1:0]         x_r;
    logic [YW-1:0]         y_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  inflight_r;
    logic [2:0]            flags_pend_r;
    logic [FW-1:0]         fifo_mem_r [4];
    logic [1:0]            wr_ptr_r, rd_ptr_r;
    logic [2:0]            fifo_cnt_r;
    logic                  last_aux_r;
    logic                  aux_pend_r;
    logic [DATA_WIDTH-1:0] aux_data_r;
    logic                  aux_valid_r;
    logic [ADDR_WIDTH-1:0] rom_addr_hold_r;

    logic                  stream_want_s, stream_gnt_s, aux_gnt_s;
    logic                  x_last_s, last_s, pop_s, push_s;
    logic [FW-1:0]         head_s;
    logic [ADDR_WIDTH-1:0] rom_addr_s;

    // Arbitration: a lone requester wins, contention alternates on last_aux_r.
    always_comb begin
        stream_want_s = 1'b0;
        aux_gnt_s     = 1'b0;
        stream_gnt_s  = 1'b0;
        if ((state_r == ST_ACTIVE) &&
            (({1'b0, fifo_cnt_r} + {3'b000, inflight_r}) < 4'd4)) begin
            stream_want_s = 1'b1;
        end else begin
            stream_want_s = 1'b0;
        end
        if (rst) begin
            aux_gnt_s    = 1'b0;
            stream_gnt_s = 1'b0;
        end else begin
            aux_gnt_s    = aux_req & (~stream_want_s | ~last_aux_r);
            stream_gnt_s = stream_want_s & ~aux_gnt_s;
        end
    end

    // Next-state decode, FIFO head view and ROM address mux.
    always_comb begin
        x_last_s = (x_r == X_LAST);
        last_s   = x_last_s && (y_r == Y_LAST);
        head_s   = fifo_mem_r[rd_ptr_r];
        push_s   = inflight_r;
        pop_s    = (fifo_cnt_r != 3'd0) & m_if.m_ready;
        state_s  = state_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_start) state_s = ST_ACTIVE;
                else             state_s = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (stream_gnt_s && last_s) state_s = ST_DRAIN;
                else                        state_s = ST_ACTIVE;
            end
            ST_DRAIN: begin
                // The eof beat is the final one, so its pop empties the pipe.
                if (pop_s && head_s[0]) state_s = ST_IDLE;
                else                    state_s = ST_DRAIN;
            end
            default: state_s = ST_IDLE;
        endcase
        if (aux_gnt_s)         rom_addr_s = aux_addr;
        else if (stream_gnt_s) rom_addr_s = addr_r;
        else                   rom_addr_s = rom_addr_hold_r;
    end

    // FSM state, busy flag, arbitration history and held ROM address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            busy_r          <= 1'b0;
            last_aux_r      <= 1'b1;
            rom_addr_hold_r <= '0;
        end else begin
            state_r         <= state_s;
            busy_r          <= (state_s != ST_IDLE);
            rom_addr_hold_r <= rom_addr_s;
            if (stream_want_s && aux_req) last_aux_r <= aux_gnt_s;
            else                          last_aux_r <= last_aux_r;
        end
    end

    // Raster counters and the one-cycle issue pipeline carrying the beat flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r          <= '0;
            y_r          <= '0;
            addr_r       <= '0;
            inflight_r   <= 1'b0;
            flags_pend_r <= 3'b000;
        end else begin
            inflight_r   <= stream_gnt_s;
            flags_pend_r <= {(addr_r == '0), x_last_s, last_s};
            if (stream_gnt_s) begin
                if (last_s) begin
                    x_r    <= '0;
                    y_r    <= '0;
                    addr_r <= '0;
                end else begin
                    addr_r <= addr_r + ADDR_WIDTH'(1);
                    if (x_last_s) begin
                        x_r <= '0;
                        y_r <= y_r + YW'(1);
                    end else begin
                        x_r <= x_r + XW'(1);
                    end
                end
            end
        end
    end

    // Four-entry output FIFO of {data, sof, eol, eof}.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) fifo_mem_r[i] <= '0;
            wr_ptr_r   <= 2'd0;
            rd_ptr_r   <= 2'd0;
            fifo_cnt_r <= 3'd0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {rom_rd_data, flags_pend_r};
                wr_ptr_r             <= wr_ptr_r + 2'd1;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + 2'd1;
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + 3'd1;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - 3'd1;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Aux read return: capture data one cycle after the grant, pulse valid after.
    always_ff @(posedge clk) begin
        if (rst) begin
            aux_pend_r  <= 1'b0;
            aux_data_r  <= '0;
            aux_valid_r <= 1'b0;
        end else begin
            aux_pend_r  <= aux_gnt_s;
            aux_valid_r <= aux_pend_r;
            if (aux_pend_r) aux_data_r <= rom_rd_data;
        end
    end

    assign busy        = busy_r;
    assign m_if.m_valid = (fifo_cnt_r != 3'd0);
    assign m_if.m_data  = head_s[FW-1:3];
    assign m_if.m_sof   = head_s[2];
    assign m_if.m_eol   = head_s[1];
    assign m_if.m_eof   = head_s[0];
    assign aux_gnt     = aux_gnt_s;
    assign aux_data    = aux_data_r;
    assign aux_valid   = aux_valid_r;
    assign rom_addr    = rom_addr_s;
endmodule

// File: tb/tb_img_rom_scan_ctrl.sv
// Bench for img_rom_scan_ctrl: a 256x256 instance for full-frame and reset
// scenarios and a 4x2 instance for stall, aux and contention scenarios.
module tb_img_rom_scan_ctrl;
    localparam int AW    = 16;
    localparam int DW    = 24;
    localparam int B_PIX = 256 * 256;
    localparam int S_W   = 4;
    localparam int S_PIX = 8;

    typedef logic [DW+2:0] beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic tb_rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic b_frame_start, b_busy, b_aux_req, b_aux_gnt, b_aux_valid;
    logic [AW-1:0] b_aux_addr, b_rom_addr;
    logic [DW-1:0] b_aux_data, b_rom_q;
    img_rom_scan_ctrl_if #(.DATA_WIDTH(DW)) b_if ();
    beat_t b_beat;
    assign b_beat = {b_if.m_data, b_if.m_sof, b_if.m_eol, b_if.m_eof};

    logic s_frame_start, s_busy, s_aux_req, s_aux_gnt, s_aux_valid;
    logic [AW-1:0] s_aux_addr, s_rom_addr;
    logic [DW-1:0] s_aux_data, s_rom_q;
    img_rom_scan_ctrl_if #(.DATA_WIDTH(DW)) s_if ();
    beat_t s_beat;
    assign s_beat = {s_if.m_data, s_if.m_sof, s_if.m_eol, s_if.m_eof};

    beat_t bq[$];
    beat_t sq[$];
    int    aq[$];

    img_rom_scan_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IMG_W(256), .IMG_H(256)) dut_b (
        .clk(clk), .rst(tb_rst), .frame_start(b_frame_start), .busy(b_busy), .m_if(b_if),
        .aux_req(b_aux_req), .aux_addr(b_aux_addr), .aux_gnt(b_aux_gnt), .aux_data(b_aux_data),
        .aux_valid(b_aux_valid), .rom_addr(b_rom_addr), .rom_rd_data(b_rom_q));

    img_rom_scan_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IMG_W(S_W), .IMG_H(2)) dut_s (
        .clk(clk), .rst(tb_rst), .frame_start(s_frame_start), .busy(s_busy), .m_if(s_if),
        .aux_req(s_aux_req), .aux_addr(s_aux_addr), .aux_gnt(s_aux_gnt), .aux_data(s_aux_data),
        .aux_valid(s_aux_valid), .rom_addr(s_rom_addr), .rom_rd_data(s_rom_q));

    always @(posedge clk) begin
        b_rom_q <= {8'h00, b_rom_addr};
        s_rom_q <= {8'h00, s_rom_addr};
    end

    function automatic beat_t mk_beat(input int i, input int w, input int n);
        logic [15:0] a;
        a = i[15:0];
        return {8'h00, a, (i == 0), ((i % w) == (w - 1)), (i == (n - 1))};
    endfunction

    task automatic test_reset();
        tb_rst = 1'b1;
        b_frame_start = 1'b0; b_aux_req = 1'b0; b_aux_addr = '0; b_if.m_ready = 1'b0;
        s_frame_start = 1'b0; s_aux_req = 1'b0; s_aux_addr = '0; s_if.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({b_if.m_valid, b_if.m_sof, b_if.m_eol, b_if.m_eof, b_busy, b_aux_gnt, b_aux_valid} !== 7'b0)
            begin n_fail++; $display("FAIL reset_big_flags got %b want 0", {b_if.m_valid, b_if.m_sof, b_if.m_eol, b_if.m_eof, b_busy, b_aux_gnt, b_aux_valid}); end
        n_checks++;
        if ({b_if.m_data, b_aux_data, b_rom_addr} !== 64'h0)
            begin n_fail++; $display("FAIL reset_big_data got %h/%h/%h want 0", b_if.m_data, b_aux_data, b_rom_addr); end
        n_checks++;
        if ({s_if.m_valid, s_if.m_sof, s_if.m_eol, s_if.m_eof, s_busy, s_aux_gnt, s_aux_valid} !== 7'b0)
            begin n_fail++; $display("FAIL reset_small_flags got %b want 0", {s_if.m_valid, s_if.m_sof, s_if.m_eol, s_if.m_eof, s_busy, s_aux_gnt, s_aux_valid}); end
        n_checks++;
        if ({s_if.m_data, s_aux_data, s_rom_addr} !== 64'h0)
            begin n_fail++; $display("FAIL reset_small_data got %h/%h/%h want 0", s_if.m_data, s_aux_data, s_rom_addr); end
        @(negedge clk);
        tb_rst = 1'b0;
    endtask

    task automatic test_full_frame();
        beat_t exp_b;
        int    cyc, eof_cyc, extra;
        bit    first_seen, done;
        bq.delete();
        b_if.m_ready = 1'b1;
        @(negedge clk);
        b_frame_start = 1'b1;
        for (int i = 0; i < B_PIX; i++) bq.push_back(mk_beat(i, 256, B_PIX));
        #1;
        n_checks++;
        if (b_busy !== 1'b0) begin n_fail++; $display("FAIL busy_before_start got %b want 0", b_busy); end
        cyc = 0; eof_cyc = -1; first_seen = 1'b0; done = 1'b0;
        while (!done && cyc < 70000) begin
            @(negedge clk);
            cyc++;
            b_frame_start = (cyc == 500);
            #1;
            if (cyc == 1) begin
                n_checks++;
                if (b_busy !== 1'b1) begin n_fail++; $display("FAIL busy_rise got %b want 1", b_busy); end
            end
            if (!first_seen && b_if.m_valid === 1'b1) begin
                first_seen = 1'b1;
                n_checks++;
                if (cyc != 3) begin n_fail++; $display("FAIL first_valid_latency got %0d want 3", cyc); end
            end
            if (first_seen) begin
                n_checks++;
                if (b_if.m_valid !== 1'b1) begin
                    n_fail++; $display("FAIL stream_gap at cycle %0d got valid %b want 1", cyc, b_if.m_valid);
                end else if (bq.size() == 0) begin
                    n_fail++; $display("FAIL extra_beat got %h want none", b_beat);
                end else begin
                    exp_b = bq.pop_front();
                    if (b_beat !== exp_b) begin n_fail++; $display("FAIL full_beat got %h want %h", b_beat, exp_b); end
                    if (exp_b[0]) begin
                        done = 1'b1; eof_cyc = cyc;
                        n_checks++;
                        if (b_busy !== 1'b1) begin n_fail++; $display("FAIL busy_at_eof got %b want 1", b_busy); end
                    end
                end
            end
        end
        b_frame_start = 1'b0;
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL full_frame_timeout got %0d beats left want 0", bq.size()); end
        n_checks++;
        if (eof_cyc != 3 + B_PIX - 1) begin n_fail++; $display("FAIL frame_length got eof at %0d want %0d", eof_cyc, 3 + B_PIX - 1); end
        @(negedge clk);
        #1;
        n_checks++;
        if (b_busy !== 1'b0) begin n_fail++; $display("FAIL busy_fall got %b want 0", b_busy); end
        extra = 0;
        repeat (10) begin @(negedge clk); #1; if (b_if.m_valid === 1'b1) extra++; end
        n_checks++;
        if (extra != 0) begin n_fail++; $display("FAIL retrigger_ignored got %0d extra beats want 0", extra); end
    endtask

    task automatic test_reset_mid_frame();
        beat_t exp_b;
        int    cyc, beats, stale;
        bq.delete();
        b_if.m_ready = 1'b1;
        @(negedge clk);
        b_frame_start = 1'b1;
        for (int i = 0; i <= 1000; i++) bq.push_back(mk_beat(i, 256, B_PIX));
        cyc = 0; beats = 0;
        while (beats < 1001 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            b_frame_start = 1'b0;
            #1;
            if (b_if.m_valid === 1'b1 && bq.size() != 0) begin
                n_checks++;
                exp_b = bq.pop_front();
                if (b_beat !== exp_b) begin n_fail++; $display("FAIL prereset_beat got %h want %h", b_beat, exp_b); end
                beats++;
            end
        end
        tb_rst = 1'b1;
        n_checks++;
        if (beats != 1001) begin n_fail++; $display("FAIL prereset_count got %0d want 1001", beats); end
        @(negedge clk);
        #1;
        n_checks++;
        if ({b_if.m_valid, b_if.m_sof, b_if.m_eol, b_if.m_eof, b_busy, b_aux_gnt, b_aux_valid} !== 7'b0)
            begin n_fail++; $display("FAIL midreset_flags got %b want 0", {b_if.m_valid, b_if.m_sof, b_if.m_eol, b_if.m_eof, b_busy, b_aux_gnt, b_aux_valid}); end
        n_checks++;
        if ({b_if.m_data, b_aux_data, b_rom_addr} !== 64'h0)
            begin n_fail++; $display("FAIL midreset_data got %h/%h/%h want 0", b_if.m_data, b_aux_data, b_rom_addr); end
        tb_rst = 1'b0;
        stale = 0;
        repeat (8) begin @(negedge clk); #1; if (b_if.m_valid === 1'b1) stale++; end
        n_checks++;
        if (stale != 0) begin n_fail++; $display("FAIL stale_after_reset got %0d beats want 0", stale); end
        bq.delete();
        for (int i = 0; i < 20; i++) bq.push_back(mk_beat(i, 256, B_PIX));
        @(negedge clk);
        b_frame_start = 1'b1;
        cyc = 0; beats = 0;
        while (beats < 20 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            b_frame_start = 1'b0;
            #1;
            if (b_if.m_valid === 1'b1 && bq.size() != 0) begin
                if (beats == 0) begin
                    n_checks++;
                    if (cyc != 3) begin n_fail++; $display("FAIL restart_latency got %0d want 3", cyc); end
                end
                n_checks++;
                exp_b = bq.pop_front();
                if (b_beat !== exp_b) begin n_fail++; $display("FAIL restart_beat got %h want %h", b_beat, exp_b); end
                beats++;
            end
        end
        n_checks++;
        if (beats != 20) begin n_fail++; $display("FAIL restart_count got %0d want 20", beats); end
        tb_rst = 1'b1;
        repeat (2) @(negedge clk);
        tb_rst = 1'b0;
    endtask

    task automatic test_stall_random();
        beat_t exp_b, prev_b;
        bit    prev_stall;
        int    cyc, beats, extra;
        sq.delete();
        for (int i = 0; i < S_PIX; i++) sq.push_back(mk_beat(i, S_W, S_PIX));
        s_if.m_ready = 1'b0;
        @(negedge clk);
        s_frame_start = 1'b1;
        cyc = 0; beats = 0; prev_stall = 1'b0; prev_b = '0;
        while (beats < S_PIX && cyc < 400) begin
            @(negedge clk);
            cyc++;
            s_frame_start = 1'b0;
            s_if.m_ready = (cyc <= 20) ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) begin
                n_checks++;
                if (s_if.m_valid !== 1'b1 || s_beat !== prev_b)
                    begin n_fail++; $display("FAIL stall_hold got %b/%h want 1/%h", s_if.m_valid, s_beat, prev_b); end
            end
            if (s_if.m_valid === 1'b1 && s_if.m_ready === 1'b1) begin
                n_checks++;
                if (sq.size() == 0) begin
                    n_fail++; $display("FAIL stall_extra got %h want none", s_beat);
                end else begin
                    exp_b = sq.pop_front();
                    if (s_beat !== exp_b) begin n_fail++; $display("FAIL stall_beat got %h want %h", s_beat, exp_b); end
                end
                beats++;
            end
            prev_stall = (s_if.m_valid === 1'b1) && (s_if.m_ready === 1'b0);
            prev_b = s_beat;
        end
        n_checks++;
        if (beats != S_PIX || sq.size() != 0) begin n_fail++; $display("FAIL stall_count got %0d want %0d", beats, S_PIX); end
        s_if.m_ready = 1'b1;
        extra = 0;
        repeat (10) begin @(negedge clk); #1; if (s_if.m_valid === 1'b1) extra++; end
        n_checks++;
        if (extra != 0 || s_busy !== 1'b0) begin n_fail++; $display("FAIL stall_tail got %0d beats busy %b want 0/0", extra, s_busy); end
    endtask

    task automatic test_aux_idle();
        @(negedge clk);
        s_aux_req = 1'b1; s_aux_addr = 16'hFFFF;
        #1;
        n_checks++;
        if (s_aux_gnt !== 1'b1 || s_rom_addr !== 16'hFFFF)
            begin n_fail++; $display("FAIL aux_idle_gnt got %b/%h want 1/ffff", s_aux_gnt, s_rom_addr); end
        @(negedge clk);
        s_aux_req = 1'b0;
        #1;
        n_checks++;
        if (s_aux_gnt !== 1'b0 || s_aux_valid !== 1'b0)
            begin n_fail++; $display("FAIL aux_idle_t1 got %b/%b want 0/0", s_aux_gnt, s_aux_valid); end
        @(negedge clk);
        #1;
        n_checks++;
        if (s_aux_valid !== 1'b1 || s_aux_data !== 24'h00FFFF || s_busy !== 1'b0)
            begin n_fail++; $display("FAIL aux_idle_t2 got %b/%h/%b want 1/00ffff/0", s_aux_valid, s_aux_data, s_busy); end
        @(negedge clk);
        #1;
        n_checks++;
        if (s_aux_valid !== 1'b0 || s_aux_data !== 24'h00FFFF)
            begin n_fail++; $display("FAIL aux_idle_hold got %b/%h want 0/00ffff", s_aux_valid, s_aux_data); end
    endtask

    task automatic test_aux_contention();
        beat_t exp_b;
        bit    exp_g, exp_v;
        int    beats;
        sq.delete();
        aq.delete();
        for (int i = 0; i < S_PIX; i++) sq.push_back(mk_beat(i, S_W, S_PIX));
        s_if.m_ready = 1'b1;
        beats = 0;
        for (int cyc = 0; cyc <= 2 * S_PIX + 6; cyc++) begin
            @(negedge clk);
            s_frame_start = (cyc == 0);
            s_aux_req  = (cyc <= 2 * S_PIX + 1);
            s_aux_addr = 16'h1234;
            #1;
            exp_g = (cyc <= 2 * S_PIX + 1) && ((cyc >= 2 * S_PIX) || (cyc % 2 == 0));
            n_checks++;
            if (s_aux_gnt !== exp_g) begin n_fail++; $display("FAIL contention_gnt cycle %0d got %b want %b", cyc, s_aux_gnt, exp_g); end
            if (s_aux_gnt === 1'b1) begin
                aq.push_back(cyc + 2);
                n_checks++;
                if (s_rom_addr !== 16'h1234) begin n_fail++; $display("FAIL contention_rom_addr got %h want 1234", s_rom_addr); end
            end
            exp_v = (aq.size() != 0) && (aq[0] == cyc);
            if (exp_v) void'(aq.pop_front());
            n_checks++;
            if (s_aux_valid !== exp_v || (exp_v && s_aux_data !== 24'h001234))
                begin n_fail++; $display("FAIL contention_aux cycle %0d got %b/%h want %b/001234", cyc, s_aux_valid, s_aux_data, exp_v); end
            if (s_if.m_valid === 1'b1) begin
                n_checks++;
                if (sq.size() == 0) begin
                    n_fail++; $display("FAIL contention_extra got %h want none", s_beat);
                end else begin
                    exp_b = sq.pop_front();
                    if (s_beat !== exp_b || cyc != 3 + 2 * beats)
                        begin n_fail++; $display("FAIL contention_beat got %h at %0d want %h at %0d", s_beat, cyc, exp_b, 3 + 2 * beats); end
                end
                beats++;
            end
        end
        n_checks++;
        if (beats != S_PIX || aq.size() != 0 || s_busy !== 1'b0)
            begin n_fail++; $display("FAIL contention_end got %0d beats %0d aux pending busy %b want %0d/0/0", beats, aq.size(), s_busy, S_PIX); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_reset_mid_frame();
        test_stall_random();
        test_aux_idle();
        test_aux_contention();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/img_rom_scan_ctrl.md
# img_rom_scan_ctrl

Read scheduler for the single-port 24-bit image ROM in the HDMI average-filter demo. It scans the stored WxH picture in raster order and feeds it to the filter/display path as a ready/valid pixel stream with frame and line markers. It also shares the ROM with a low-rate auxiliary random-access port for debug, coefficient and probe reads. It owns the only address input of the ROM.

## Interface
Parameters:
- ADDR_WIDTH, 16, ROM address width
- DATA_WIDTH, 24, ROM word width (RGB888)
- IMG_W, 256, pixels per line
- IMG_H, 256, lines per frame; IMG_W*IMG_H ≤ 2**ADDR_WIDTH

Ports:
- clk  in  1  single clock for the block and the ROM
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  pulse; starts one frame scan when idle
- busy  out  1  high from the cycle after an accepted frame_start until the last stream beat is accepted
- m_data  out  DATA_WIDTH  pixel
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- m_sof  out  1  with first pixel of frame
- m_eol  out  1  with last pixel of each line
- m_eof  out  1  with last pixel of frame
- aux_req  in  1  level request for one aux read
- aux_addr  in  ADDR_WIDTH  aux address; stable while aux_req is high
- aux_gnt  out  1  combinational; read issued this cycle
- aux_data  out  DATA_WIDTH  last aux read result, held
- aux_valid  out  1  one-cycle pulse when aux_data updates
- rom_addr  out  ADDR_WIDTH  combinational mux output to ROM
- rom_rd_data  in  DATA_WIDTH  ROM data; valid in cycle t+1 for an address presented in cycle t

## Operation
- FSM states:
  - IDLE: frame_start seen at the end of cycle t0 → ACTIVE. frame_start in other states is ignored.
  - ACTIVE: issues stream addresses 0 … IMG_W*IMG_H−1 through x/y counters plus a linear address counter. After the last address issues → DRAIN.
  - DRAIN: waits for the in-flight read to land and the FIFO to empty → IDLE.
- Stream issue condition: ACTIVE and (fifo_count + inflight) < 4. inflight = 1 if the stream issued in the previous cycle.
- Output FIFO: 4 entries, DATA_WIDTH+3 bits wide (data, sof, eol, eof). Flags are computed at issue time and delayed one cycle with the read.
  - sof: addr == 0.
  - eol: x == IMG_W−1.
  - eof: last address.
- FIFO write occurs at the end of t+1. Pop occurs on m_valid & m_ready. Push and pop can happen in the same cycle; count is unchanged.
- Arbitration, one ROM access per cycle:
  - A lone requester wins.
  - If the stream and aux_req contend, the grant alternates using a last_winner flag. The stream wins the first contention after reset.
  - aux may issue in any state, including IDLE.
- Aux path: on a grant in cycle t, rom_rd_data is registered into aux_data at the end of t+1, and aux_valid is high in cycle t+2. The requester drops or changes aux_req after seeing aux_gnt. aux_req held high means back-to-back reads of aux_addr.
- rom_addr = aux_addr when aux is granted, else the stream address. The value is don't-care when nothing issues, but must be held stable.
- Reset:
  - Outputs: m_valid, m_sof, m_eol, m_eof, busy, aux_gnt, aux_valid = 0; m_data, aux_data, rom_addr = 0.
  - Internal: FIFO empty, counters 0, last_winner = aux (so the stream wins next), FSM IDLE.
  - Reset mid-frame discards the in-flight read. Its data must not appear on either port.

## Timing
- frame_start sampled high at the end of t0: first stream issue in t0+1, first m_valid in t0+3 with m_sof=1.
- m_ready held high with no aux traffic: one pixel per cycle, no bubbles, the whole frame in IMG_W*IMG_H consecutive cycles.
- Under continuous aux contention, stream throughput is at most 1/2.
- busy falls in the cycle after the eof beat handshake.
- m_data and flags stay stable while m_valid & !m_ready.
- At most 4 pixels are buffered or in flight. No overflow under any m_ready pattern.

## Test plan
ROM model: mem[a] = {8'h00, a}.
- Full frame, default parameters, m_ready=1, no aux → 65536 beats with data 0x000000…0x00FFFF, no gaps. m_sof on beat 0, m_eol on beats 255, 511, …, m_eof on 65535. First m_valid 3 cycles after the frame_start cycle. busy deasserts 1 cycle after the last beat.
- IMG_W=4, IMG_H=2; m_ready low for 20 cycles, then random → exactly 8 beats 0…7, eol on beats 3 and 7, eof on 7. Data is stable during stalls. FIFO occupancy never exceeds 4.
- Aux contention: aux_req held with aux_addr=0x1234 during a streaming frame → aux_gnt alternates with stream issues. aux_data=0x001234 with an aux_valid pulse 2 cycles after each grant. The stream stays in order with no loss.
- Aux in IDLE with aux_addr=0xFFFF for one cycle → aux_gnt in the same cycle, aux_valid and aux_data=0x00FFFF two cycles later. busy stays 0.
- frame_start pulsed again mid-frame → ignored, and the frame completes normally.
- rst asserted at beat 1000 → next cycle all outputs are 0. A following frame_start restarts at pixel 0 with m_sof. No stale data is emitted.
